scoreboard: RTL and testbench

SCOREBOARD -- requirements
Module: scoreboard

---
 rtl/ariane_pkg.sv | 37 +++
 rtl/scoreboard_rs_lookup.sv | 54 +++++
 rtl/scoreboard.sv | 145 ++++++++++++++
 tb/tb_scoreboard.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ariane_pkg.sv
// Shared core types: scoreboard entry, exception and functional-unit
// encodings, plus the default scoreboard depth.
package ariane_pkg;

    localparam int unsigned NR_SB_ENTRIES = 8;
    // Wide enough to tag the largest legal scoreboard (32 slots)
    localparam int unsigned TRANS_ID_BITS = 5;

    typedef enum logic [2:0] {
        NONE,
        LOAD,
        STORE,
        ALU,
        CTRL_FLOW,
        MULT,
        CSR
    } fu_t;

    typedef struct packed {
        logic [63:0] cause;
        logic [63:0] tval;
        logic        valid;
    } exception_t;

    typedef struct packed {
        logic [63:0]              pc;
        logic [TRANS_ID_BITS-1:0] trans_id;
        fu_t                      fu;
        logic [4:0]               rs1;
        logic [4:0]               rs2;
        logic [4:0]               rd;
        logic [63:0]              result;
        logic                     valid;
        exception_t               ex;
    } scoreboard_entry_t;

endpackage

// File: rtl/scoreboard_rs_lookup.sv
// Youngest-match source-register lookup over the in-flight slots.
// Forwarding of written results is enabled by SB_FORWARD_EN.
module sb_rs_lookup
    import ariane_pkg::*;
#(
    parameter int unsigned NR_ENTRIES = NR_SB_ENTRIES
) (
    input  logic [NR_ENTRIES-1:0]                    occupied_i,
    input  logic [NR_ENTRIES-1:0][4:0]               rd_i,
    input  logic [NR_ENTRIES-1:0]                    valid_i,
    input  logic [NR_ENTRIES-1:0][63:0]              result_i,
    input  logic [$clog2(NR_ENTRIES)-1:0]            issue_ptr_i,
    input  logic [4:0]                               rs_i,
    output logic                                     busy_o,
    output logic                                     fwd_valid_o,
    output logic [63:0]                              fwd_o
);

    localparam int unsigned IDW = $clog2(NR_ENTRIES);

    logic           hit;
    logic           hit_valid;
    logic [63:0]    hit_res;
    logic [IDW-1:0] idx;

    // Walk oldest-to-youngest behind the issue pointer; last hit wins.
    always_comb begin
        hit       = 1'b0;
        hit_valid = 1'b0;
        hit_res   = '0;
        idx       = '0;
        for (int i = NR_ENTRIES; i >= 1; i--) begin
            idx = issue_ptr_i - IDW'(i);
            if (occupied_i[idx] && rd_i[idx] == rs_i) begin
                hit       = 1'b1;
                hit_valid = valid_i[idx];
                hit_res   = result_i[idx];
            end
        end
    end

    assign busy_o = hit && (rs_i != 5'd0);

`ifdef SB_FORWARD_EN
    assign fwd_valid_o = busy_o && hit_valid;
    assign fwd_o       = hit_res;
`else
    logic unused_fwd;
    assign unused_fwd  = ^{hit_valid, hit_res};
    assign fwd_valid_o = 1'b0;
    assign fwd_o       = '0;
`endif

endmodule

// File: rtl/scoreboard.sv
// In-order issue/commit scoreboard with out-of-order writeback.
// Define SB_FORWARD_EN to forward written results to rs lookups.
module scoreboard
    import ariane_pkg::*;
#(
    parameter int unsigned NR_ENTRIES  = NR_SB_ENTRIES,
    parameter int unsigned NR_WB_PORTS = 2
) (
    input  logic                                        clk_i,
    input  logic                                        rst_ni,
    input  logic                                        flush_i,
    input  scoreboard_entry_t                           issue_instr_i,
    input  logic                                        issue_valid_i,
    output logic                                        issue_ready_o,
    output logic [$clog2(NR_ENTRIES)-1:0]               issue_trans_id_o,
    input  logic [NR_WB_PORTS-1:0]                      wb_valid_i,
    input  logic [NR_WB_PORTS-1:0][$clog2(NR_ENTRIES)-1:0] wb_trans_id_i,
    input  logic [NR_WB_PORTS-1:0][63:0]                wb_result_i,
    input  exception_t [NR_WB_PORTS-1:0]                wb_ex_i,
    output scoreboard_entry_t                           commit_instr_o,
    output logic                                        commit_valid_o,
    input  logic                                        commit_ack_i,
    input  logic [4:0]                                  rs1_i,
    input  logic [4:0]                                  rs2_i,
    output logic                                        rs1_busy_o,
    output logic                                        rs2_busy_o,
    output logic                                        rs1_fwd_valid_o,
    output logic                                        rs2_fwd_valid_o,
    output logic [63:0]                                 rs1_fwd_o,
    output logic [63:0]                                 rs2_fwd_o
);

    localparam int unsigned IDW = $clog2(NR_ENTRIES);
    localparam int unsigned CW  = IDW + 1;

    scoreboard_entry_t [NR_ENTRIES-1:0] mem_q, mem_d;
    logic [NR_ENTRIES-1:0]              occ_q, occ_d;
    logic [IDW-1:0]                     iptr_q, iptr_d;
    logic [IDW-1:0]                     cptr_q, cptr_d;
    logic [CW-1:0]                      cnt_q, cnt_d;

    logic issue_fire;
    logic commit_fire;

    assign issue_ready_o    = (cnt_q != CW'(NR_ENTRIES)) && !flush_i;
    assign issue_trans_id_o = iptr_q;
    assign commit_instr_o   = mem_q[cptr_q];
    assign commit_valid_o   = occ_q[cptr_q] && mem_q[cptr_q].valid;

    assign issue_fire  = issue_valid_i && issue_ready_o;
    assign commit_fire = commit_ack_i && commit_valid_o;

    always_comb begin
        mem_d  = mem_q;
        occ_d  = occ_q;
        iptr_d = iptr_q;
        cptr_d = cptr_q;
        cnt_d  = cnt_q + CW'(issue_fire) - CW'(commit_fire);

        if (issue_fire) begin
            mem_d[iptr_q]          = issue_instr_i;
            mem_d[iptr_q].valid    = 1'b0;
            mem_d[iptr_q].trans_id = TRANS_ID_BITS'(iptr_q);
            occ_d[iptr_q]          = 1'b1;
            iptr_d                 = iptr_q + 1'b1;
        end

        // Ascending port order lets the highest port win on a shared slot
        for (int k = 0; k < NR_WB_PORTS; k++) begin
            if (wb_valid_i[k] && occ_q[wb_trans_id_i[k]]) begin
                mem_d[wb_trans_id_i[k]].result = wb_result_i[k];
                mem_d[wb_trans_id_i[k]].ex     = wb_ex_i[k];
                mem_d[wb_trans_id_i[k]].valid  = 1'b1;
            end
        end

        if (commit_fire) begin
            occ_d[cptr_q] = 1'b0;
            cptr_d        = cptr_q + 1'b1;
        end

        if (flush_i) begin
            occ_d  = '0;
            iptr_d = '0;
            cptr_d = '0;
            cnt_d  = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q  <= '0;
            occ_q  <= '0;
            iptr_q <= '0;
            cptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            mem_q  <= mem_d;
            occ_q  <= occ_d;
            iptr_q <= iptr_d;
            cptr_q <= cptr_d;
            cnt_q  <= cnt_d;
        end
    end

    logic [NR_ENTRIES-1:0][4:0]  rd_arr;
    logic [NR_ENTRIES-1:0]       vld_arr;
    logic [NR_ENTRIES-1:0][63:0] res_arr;

    always_comb begin
        rd_arr  = '0;
        vld_arr = '0;
        res_arr = '0;
        for (int i = 0; i < NR_ENTRIES; i++) begin
            rd_arr[i]  = mem_q[i].rd;
            vld_arr[i] = mem_q[i].valid;
            res_arr[i] = mem_q[i].result;
        end
    end

    sb_rs_lookup #(.NR_ENTRIES(NR_ENTRIES)) u_rs1_lookup (
        .occupied_i  (occ_q),
        .rd_i        (rd_arr),
        .valid_i     (vld_arr),
        .result_i    (res_arr),
        .issue_ptr_i (iptr_q),
        .rs_i        (rs1_i),
        .busy_o      (rs1_busy_o),
        .fwd_valid_o (rs1_fwd_valid_o),
        .fwd_o       (rs1_fwd_o)
    );

    sb_rs_lookup #(.NR_ENTRIES(NR_ENTRIES)) u_rs2_lookup (
        .occupied_i  (occ_q),
        .rd_i        (rd_arr),
        .valid_i     (vld_arr),
        .result_i    (res_arr),
        .issue_ptr_i (iptr_q),
        .rs_i        (rs2_i),
        .busy_o      (rs2_busy_o),
        .fwd_valid_o (rs2_fwd_valid_o),
        .fwd_o       (rs2_fwd_o)
    );

endmodule

// File: tb/tb_scoreboard.sv
// Directed bench for scoreboard: vector table plus corner sequences.
// Expected forwarding values follow SB_FORWARD_EN.
module tb_scoreboard;
    import ariane_pkg::*;

`ifdef SB_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    logic flush;
    scoreboard_entry_t instr;
    logic issue_valid;
    logic issue_ready;
    logic [2:0] issue_tid;
    logic [1:0] wb_valid;
    logic [1:0][2:0] wb_id;
    logic [1:0][63:0] wb_res;
    exception_t [1:0] wb_ex;
    scoreboard_entry_t commit_instr;
    logic commit_valid;
    logic ack;
    logic [4:0] rs1, rs2;
    logic b1, b2, fv1, fv2;
    logic [63:0] f1, f2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    scoreboard dut (
        .clk_i            (clk),
        .rst_ni           (rst_ni),
        .flush_i          (flush),
        .issue_instr_i    (instr),
        .issue_valid_i    (issue_valid),
        .issue_ready_o    (issue_ready),
        .issue_trans_id_o (issue_tid),
        .wb_valid_i       (wb_valid),
        .wb_trans_id_i    (wb_id),
        .wb_result_i      (wb_res),
        .wb_ex_i          (wb_ex),
        .commit_instr_o   (commit_instr),
        .commit_valid_o   (commit_valid),
        .commit_ack_i     (ack),
        .rs1_i            (rs1),
        .rs2_i            (rs2),
        .rs1_busy_o       (b1),
        .rs2_busy_o       (b2),
        .rs1_fwd_valid_o  (fv1),
        .rs2_fwd_valid_o  (fv2),
        .rs1_fwd_o        (f1),
        .rs2_fwd_o        (f2)
    );

    typedef struct {
        logic iv; logic [4:0] rd;
        logic w0v; logic [2:0] w0id; logic [63:0] w0r;
        logic w1v; logic [2:0] w1id; logic [63:0] w1r;
        logic ack; logic fl; logic [4:0] rs1; logic [4:0] rs2;
        logic e_rdy; logic [2:0] e_tid; logic e_cv; logic [63:0] e_cres;
        logic e_b1; logic e_fv1; logic [63:0] e_f1; logic e_b2;
    } vec_t;

    typedef struct {
        logic [2:0] tid; logic [63:0] res; logic [4:0] rd; bit wr;
    } q_t;

    vec_t vecs[18];
    q_t q[$];

    function automatic logic [63:0] fw(input logic [63:0] v);
        return FWD ? v : 64'h0;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic idle();
        issue_valid = 1'b0;
        instr       = '0;
        instr.valid = 1'b1;
        instr.pc    = 64'h8000_0000;
        instr.fu    = ALU;
        wb_valid    = '0;
        wb_id       = '0;
        wb_res      = '0;
        wb_ex       = '0;
        ack         = 1'b0;
        flush       = 1'b0;
        rs1         = '0;
        rs2         = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle();
        rst_ni = 1'b0;
        @(negedge clk);
        #1;
        chk("rst.ready", 64'(issue_ready), 64'd1);
        chk("rst.cvalid", 64'(commit_valid), 64'd0);
        chk("rst.tid", 64'(issue_tid), 64'd0);
        chk("rst.busy", 64'({b1, b2, fv1, fv2}), 64'd0);
        @(negedge clk);
        rst_ni = 1'b1;
    endtask

    task automatic apply(input vec_t v, input int i);
        idle();
        issue_valid = v.iv;
        instr.rd    = v.rd;
        wb_valid    = {v.w1v, v.w0v};
        wb_id[0]    = v.w0id;
        wb_id[1]    = v.w1id;
        wb_res[0]   = v.w0r;
        wb_res[1]   = v.w1r;
        ack         = v.ack;
        flush       = v.fl;
        rs1         = v.rs1;
        rs2         = v.rs2;
        #1;
        chk($sformatf("v%0d.ready", i), 64'(issue_ready), 64'(v.e_rdy));
        chk($sformatf("v%0d.tid", i), 64'(issue_tid), 64'(v.e_tid));
        chk($sformatf("v%0d.cvalid", i), 64'(commit_valid), 64'(v.e_cv));
        if (v.e_cv)
            chk($sformatf("v%0d.cres", i), commit_instr.result, v.e_cres);
        chk($sformatf("v%0d.busy1", i), 64'(b1), 64'(v.e_b1));
        chk($sformatf("v%0d.fv1", i), 64'(fv1), 64'(v.e_fv1));
        chk($sformatf("v%0d.fwd1", i), f1, v.e_f1);
        chk($sformatf("v%0d.busy2", i), 64'(b2), 64'(v.e_b2));
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] miptr;
        logic [2:0] prev_tid;
        bit prev_ok;
        bit exp_rdy, exp_cv;
        q_t e;

        //         iv rd  w0v id  res       w1v id res      ak fl r1 r2   rdy tid cv cres      b1 fv1 f1            b2
        vecs[0]  = '{0, 0, 0, 0, 0,        0, 0, 0,        0, 0, 0, 0,  1, 0, 0, 0,         0, 0,  0,            0};
        vecs[1]  = '{1, 5, 0, 0, 0,        0, 0, 0,        0, 0, 5, 0,  1, 0, 0, 0,         0, 0,  0,            0};
        vecs[2]  = '{0, 0, 1, 0, 64'hDEAD, 0, 0, 0,        0, 0, 5, 5,  1, 1, 0, 0,         1, 0,  0,            1};
        vecs[3]  = '{0, 0, 0, 0, 0,        0, 0, 0,        0, 0, 5, 0,  1, 1, 1, 64'hDEAD,  1, FWD, fw(64'hDEAD), 0};
        vecs[4]  = '{0, 0, 0, 0, 0,        0, 0, 0,        1, 0, 5, 0,  1, 1, 1, 64'hDEAD,  1, FWD, fw(64'hDEAD), 0};
        vecs[5]  = '{0, 0, 0, 0, 0,        0, 0, 0,        0, 0, 5, 0,  1, 1, 0, 0,         0, 0,  0,            0};
        vecs[6]  = '{0, 0, 0, 0, 0,        0, 0, 0,        0, 1, 0, 0,  0, 1, 0, 0,         0, 0,  0,            0};
        vecs[7]  = '{1, 3, 0, 0, 0,        0, 0, 0,        0, 0, 0, 0,  1, 0, 0, 0,         0, 0,  0,            0};
        vecs[8]  = '{1, 3, 0, 0, 0,        0, 0, 0,        0, 0, 3, 0,  1, 1, 0, 0,         1, 0,  0,            0};
        vecs[9]  = '{0, 0, 1, 1, 64'h11,   0, 0, 0,        0, 0, 3, 0,  1, 2, 0, 0,         1, 0,  0,            0};
        vecs[10] = '{0, 0, 1, 0, 64'h22,   0, 0, 0,        0, 0, 3, 3,  1, 2, 0, 0,         1, FWD, fw(64'h11),   1};
        vecs[11] = '{1, 7, 0, 0, 0,        0, 0, 0,        0, 0, 3, 0,  1, 2, 1, 64'h22,    1, FWD, fw(64'h11),   0};
        vecs[12] = '{0, 0, 1, 2, 64'hA,    1, 2, 64'hB,    0, 0, 7, 0,  1, 3, 1, 64'h22,    1, 0,  0,            0};
        vecs[13] = '{0, 0, 1, 5, 64'h55,   0, 0, 0,        0, 0, 7, 0,  1, 3, 1, 64'h22,    1, FWD, fw(64'hB),    0};
        vecs[14] = '{0, 0, 0, 0, 0,        0, 0, 0,        1, 0, 7, 0,  1, 3, 1, 64'h22,    1, FWD, fw(64'hB),    0};
        vecs[15] = '{0, 0, 0, 0, 0,        0, 0, 0,        1, 0, 3, 0,  1, 3, 1, 64'h11,    1, FWD, fw(64'h11),   0};
        vecs[16] = '{0, 0, 0, 0, 0,        0, 0, 0,        1, 0, 3, 0,  1, 3, 1, 64'hB,     0, 0,  0,            0};
        vecs[17] = '{0, 0, 0, 0, 0,        0, 0, 0,        0, 0, 7, 0,  1, 3, 0, 0,         0, 0,  0,            0};

        do_reset();
        @(negedge clk);
        foreach (vecs[i]) apply(vecs[i], i);

        // Fill all slots with no commit; a ninth issue must bounce
        do_reset();
        for (int i = 0; i < 8; i++) begin
            idle();
            issue_valid = 1'b1;
            instr.rd    = 5'(i + 1);
            #1;
            chk($sformatf("fill%0d.ready", i), 64'(issue_ready), 64'd1);
            chk($sformatf("fill%0d.tid", i), 64'(issue_tid), 64'(i));
            tick();
        end
        idle();
        issue_valid = 1'b1;
        instr.rd    = 5'd31;
        #1;
        chk("full.ready", 64'(issue_ready), 64'd0);
        chk("full.tid", 64'(issue_tid), 64'd0);
        tick();
        for (int j = 0; j < 4; j++) begin
            idle();
            wb_valid  = 2'b11;
            wb_id[0]  = 3'(2 * j);
            wb_id[1]  = 3'(2 * j + 1);
            wb_res[0] = 64'(100 + 2 * j);
            wb_res[1] = 64'(101 + 2 * j);
            tick();
        end

        // Issue+ack at full, then stream entries through the wrap
        q.delete();
        for (int i = 0; i < 8; i++) begin
            e.tid = 3'(i); e.res = 64'(100 + i); e.rd = 5'(i + 1); e.wr = 1'b1;
            q.push_back(e);
        end
        miptr   = 3'd0;
        prev_ok = 1'b0;
        prev_tid = 3'd0;
        for (int n = 0; n < 24; n++) begin
            idle();
            issue_valid = 1'b1;
            instr.rd    = 5'((n % 30) + 1);
            ack         = 1'b1;
            if (prev_ok) begin
                wb_valid[1] = 1'b1;
                wb_id[1]    = prev_tid;
                wb_res[1]   = 64'(200 + n - 1);
            end
            #1;
            exp_rdy = (q.size() != 8);
            exp_cv  = (q.size() > 0) && q[0].wr;
            chk($sformatf("cyc%0d.ready", n), 64'(issue_ready), 64'(exp_rdy));
            chk($sformatf("cyc%0d.tid", n), 64'(issue_tid), 64'(miptr));
            chk($sformatf("cyc%0d.cvalid", n), 64'(commit_valid), 64'(exp_cv));
            if (exp_cv) begin
                chk($sformatf("cyc%0d.cres", n), commit_instr.result, q[0].res);
                chk($sformatf("cyc%0d.crd", n), 64'(commit_instr.rd), 64'(q[0].rd));
            end
            tick();
            if (prev_ok)
                foreach (q[j]) if (q[j].tid == prev_tid) q[j].wr = 1'b1;
            if (exp_cv) void'(q.pop_front());
            prev_ok = exp_rdy;
            if (exp_rdy) begin
                e.tid = miptr; e.res = 64'(200 + n);
                e.rd = 5'((n % 30) + 1); e.wr = 1'b0;
                q.push_back(e);
                prev_tid = miptr;
                miptr    = miptr + 3'd1;
            end
        end

        // Flush with five pending entries and a concurrent writeback
        do_reset();
        for (int i = 0; i < 5; i++) begin
            idle();
            issue_valid = 1'b1;
            instr.rd    = 5'd9;
            tick();
        end
        idle();
        ack = 1'b1;
        #1;
        chk("ackinv.cvalid", 64'(commit_valid), 64'd0);
        tick();
        idle();
        flush       = 1'b1;
        issue_valid = 1'b1;
        wb_valid    = 2'b01;
        wb_id[0]    = 3'd0;
        wb_res[0]   = 64'h99;
        #1;
        chk("flush.ready_pre", 64'(issue_ready), 64'd0);
        chk("flush.tid_pre", 64'(issue_tid), 64'd5);
        tick();
        idle();
        rs1 = 5'd9;
        #1;
        chk("flush.cvalid", 64'(commit_valid), 64'd0);
        chk("flush.ready", 64'(issue_ready), 64'd1);
        chk("flush.tid", 64'(issue_tid), 64'd0);
        chk("flush.busy", 64'(b1), 64'd0);

        // Ack on an occupied but unwritten slot must be ignored
        idle();
        issue_valid = 1'b1;
        instr.rd    = 5'd4;
        tick();
        idle();
        ack = 1'b1;
        tick();
        idle();
        wb_valid  = 2'b10;
        wb_id[1]  = 3'd0;
        wb_res[1] = 64'h77;
        tick();
        idle();
        #1;
        chk("ackign.cvalid", 64'(commit_valid), 64'd1);
        chk("ackign.cres", commit_instr.result, 64'h77);
        chk("ackign.tid", 64'(issue_tid), 64'd1);

        // Reset mid-flight drops the pending entry without a commit
        idle();
        issue_valid = 1'b1;
        instr.rd    = 5'd6;
        #2;
        rst_ni = 1'b0;
        #1;
        chk("mrst.cvalid", 64'(commit_valid), 64'd0);
        chk("mrst.ready", 64'(issue_ready), 64'd1);
        chk("mrst.tid", 64'(issue_tid), 64'd0);
        rs1 = 5'd4;
        #1;
        chk("mrst.busy", 64'(b1), 64'd0);
        @(negedge clk);
        idle();
        rst_ni = 1'b1;
        tick();
        #1;
        chk("post.cvalid", 64'(commit_valid), 64'd0);
        chk("post.tid", 64'(issue_tid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
